cursor_sprite_overlay: RTL
==========================

Name: cursor_sprite_overlay

Overview:
- Reader for the 16x16 arrow cursor bitmap ROM: 5-bit address, 8-bit data, combinational read.
- The ROM holds two bytes per row: the even address is the left 8 pixels, the odd address the right 8 pixels, MSB is the leftmost pixel. A bit value of 0 is opaque cursor and 1 is transparent.
- During horizontal blanking the block fetches the next scanline's cursor row into a line buffer, then overlays the cursor onto the VGA pixel stream at a frame-latched position.
- Sits between the game renderer's pixel output and the VGA output register.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- FETCH_X, 648, pix_x value at which the next line's row fetch starts; must be ≥ H_ACTIVE and ≤ H_TOTAL-3.
- V_TOTAL, 525, total lines per frame; the last line is V_TOTAL-1.
- CURSOR_COLOR, 8'hFF, RGB332 colour of opaque cursor pixels.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- pix_x  in  10  current horizontal counter
- pix_y  in  10  current vertical counter
- video_on  in  1  active-video flag for pix_x/pix_y
- pix_in  in  8  background RGB332 pixel for pix_x/pix_y
- cur_x  in  10  requested cursor left column
- cur_y  in  10  requested cursor top line
- cursor_en  in  1  cursor visible request
- rom_addr  out  5  address to the cursor ROM
- rom_data  in  8  ROM data, valid in the same cycle as rom_addr
- pix_out  out  8  composited pixel
- video_on_out  out  1  video_on delayed to align with pix_out

Behaviour:
- Reset: pix_out=0, video_on_out=0, rom_addr=0, FSM=IDLE, line_buf=16'hFFFF, line_valid=0, latched cur_x/cur_y=0, latched enable=0. Reset asserted mid-fetch aborts the fetch; the following line is drawn without cursor.
- Frame latch: on the cycle pix_y==V_TOTAL-1 and pix_x==0, capture cur_x, cur_y and cursor_en. Changes to these inputs mid-frame have no effect until the next latch.
- next_y = (pix_y==V_TOTAL-1) ? 0 : pix_y+1. row = next_y - lat_y, computed as a 10-bit unsigned value; the row is in range iff row<16 and the latched enable is 1.
- FSM states: IDLE, FETCH_L, FETCH_R.
  - IDLE → FETCH_L when pix_x==FETCH_X. In this cycle:
    - If the row is in range: drive rom_addr={row[3:0],1'b0} and store rom_data into line_buf[15:8].
    - If the row is out of range: set line_valid=0 and return to IDLE instead.
  - FETCH_L → FETCH_R: drive rom_addr={row[3:0],1'b1}, store rom_data into line_buf[7:0], set line_valid=1.
  - FETCH_R → IDLE unconditionally.
  - row is registered at the IDLE→FETCH_L transition so both bytes come from the same row.
- rom_addr holds its last value when not fetching.
- Overlay stage, 1-cycle latency:
  - col = pix_x - lat_x (10-bit).
  - hit = video_on & line_valid & (pix_x ≥ lat_x) & (col<16) & ~line_buf[15-col[3:0]].
  - Registered: pix_out = !video_on ? 0 : (hit ? CURSOR_COLOR : pix_in); video_on_out = video_on.
- Right-edge clipping: columns ≥ H_ACTIVE are suppressed by video_on. Bottom wrap: rows whose line index exceeds V_TOTAL-1 are never drawn; the cursor never wraps to the top of the frame.
- line_buf is only updated during blanking, so the active line always uses a complete row.

Test Plan:
- Reset, then cursor_en=1, cur=(100,50), use the arrow ROM, run 2 frames → on line 50: x=100 transparent (pix_in passes), x=101–102 CURSOR_COLOR, x=103–115 pix_in; on line 49 at pix_x=648/649, rom_addr=0 then 1.
- Same setup, line 60 (row 10, bytes 0x80/0x07) → x=100 transparent, x=101–112 CURSOR_COLOR, x=113–115 transparent; line 66 shows pix_in across all columns.
- Change cur_x to 300 mid-frame at line 200 → the current frame still draws at x=100; the next frame draws at x=300.
- cur=(632,520) → on line 520, columns 632–639 composited and nothing drawn beyond x=639; lines 0–10 of the next frame show no cursor; the fetch on line 524 reports out of range (line_valid=0).
- Assert rst for 1 cycle at pix_x=649 on line 54 → that line's fetch is aborted, line 55 shows no cursor, and pix_out/video_on_out read 0 the cycle after reset; the cursor stays absent until the next frame latch restores it (the latched enable is cleared by reset).
- cursor_en=0 latched → pix_out equals pix_in delayed by 1 cycle on every active pixel, and is 0 whenever video_on=0.

Source files
------------

// File: rtl/cursor_sprite_overlay.sv
// cursor_sprite_overlay: overlays a 16x16 one-bit cursor bitmap on the VGA pixel stream.
// During horizontal blanking, the block fetches the next scanline's cursor row from a
// combinational ROM into a line buffer. The cursor position and enable are latched
// once per frame, and the composited pixel is registered with a latency of one cycle.
module cursor_sprite_overlay #(
    parameter int          H_ACTIVE     = 640,
    parameter int          FETCH_X      = 648,
    parameter int          V_TOTAL      = 525,
    parameter logic [7:0]  CURSOR_COLOR = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       video_on,
    input  logic [7:0] pix_in,
    input  logic [9:0] cur_x,
    input  logic [9:0] cur_y,
    input  logic       cursor_en,
    output logic [4:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic [7:0] pix_out,
    output logic       video_on_out
);

    localparam logic [9:0] FETCH_X_L  = 10'(FETCH_X);
    localparam logic [9:0] LAST_Y     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACTIVE_L = 10'(H_ACTIVE);

    typedef enum logic [1:0] {IDLE, FETCH_L, FETCH_R} state_t;

    state_t      state;
    logic [15:0] line_buf;     // MSB = leftmost pixel; 0 = opaque
    logic        line_valid;
    logic [3:0]  row_q;        // row held across both byte fetches
    logic [4:0]  addr_q;       // last address driven, held while idle
    logic [9:0]  lat_x;
    logic [9:0]  lat_y;
    logic        lat_en;

    logic [9:0]  next_y;
    logic [9:0]  row;
    logic        row_in_range;
    logic        fetch_start;
    logic [9:0]  col;
    logic        pix_bit;
    logic        hit;

    // This logic derives the row of the next scanline and decides whether that row
    // falls inside the cursor. The row is an unsigned 10-bit difference, so lines
    // above the cursor wrap to large values and drop out of range. As a result, the
    // cursor never wraps from the bottom of the frame to the top.
    always_comb begin
        next_y       = (pix_y == LAST_Y) ? 10'd0 : pix_y + 10'd1;
        row          = next_y - lat_y;
        row_in_range = (row < 10'd16) && lat_en;
        fetch_start  = (state == IDLE) && (pix_x == FETCH_X_L);
    end

    // The ROM address is driven combinationally during the two fetch cycles, because
    // the data returns in the same cycle. Outside those cycles, the address keeps its
    // last driven value.
    always_comb begin
        rom_addr = addr_q;
        if (fetch_start && row_in_range) begin
            rom_addr = {row[3:0], 1'b0};
        end else if (state == FETCH_L) begin
            rom_addr = {row_q, 1'b1};
        end
    end

    // Fetch FSM: loads the left byte and then the right byte of the next line's row
    // during blanking. When a reset arrives in the middle of a fetch, the fetch is
    // abandoned and the line is left invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            line_buf   <= 16'hFFFF;
            line_valid <= 1'b0;
            row_q      <= 4'd0;
            addr_q     <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_start) begin
                        if (row_in_range) begin
                            row_q          <= row[3:0];
                            line_buf[15:8] <= rom_data;
                            addr_q         <= rom_addr;
                            state          <= FETCH_L;
                        end else begin
                            line_valid <= 1'b0;
                        end
                    end
                end
                FETCH_L: begin
                    line_buf[7:0] <= rom_data;
                    line_valid    <= 1'b1;
                    addr_q        <= rom_addr;
                    state         <= FETCH_R;
                end
                FETCH_R: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // The frame latch samples the cursor request once per frame, at the start of the
    // last line, so that changes made mid-frame take effect only in the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_x  <= 10'd0;
            lat_y  <= 10'd0;
            lat_en <= 1'b0;
        end else if (pix_y == LAST_Y && pix_x == 10'd0) begin
            lat_x  <= cur_x;
            lat_y  <= cur_y;
            lat_en <= cursor_en;
        end
    end

    // Hit test against the line buffer. The H_ACTIVE guard repeats the clipping that
    // video_on already provides; it keeps the cursor inside the visible width even if
    // the renderer holds video_on too long.
    always_comb begin
        col     = pix_x - lat_x;
        pix_bit = line_buf[4'd15 - col[3:0]];
        hit     = video_on && line_valid && (pix_x >= lat_x) && (col < 10'd16)
                  && !pix_bit && (pix_x < H_ACTIVE_L);
    end

    // Overlay output register: during blanking the output is black; otherwise it is
    // the cursor colour or the background pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_out      <= 8'd0;
            video_on_out <= 1'b0;
        end else begin
            pix_out      <= !video_on ? 8'd0 : (hit ? CURSOR_COLOR : pix_in);
            video_on_out <= video_on;
        end
    end

endmodule
